// File: rtl/iter_divider.sv
// Restoring shift-subtract DIV/DIVU/REM/REMU; XLEN+2 edges normal, 1 edge for div-by-zero/overflow; result held until out_ready.
// Optional synchronous abort port `flush` is enabled by defining ITER_DIVIDER_FLUSH_EN.
module iter_divider #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
`ifdef ITER_DIVIDER_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] Y,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] OUTPUT,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sgn_q, sgn_d;
  logic              is_rem_q, is_rem_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   out_q, out_d;

  logic              abort;
  logic              x_neg, y_neg;
  logic [XLEN-1:0]   x_abs, y_abs;
  logic              y_zero, ovf;
  logic [XLEN:0]     rem_sh;
  logic              ge;
  logic [XLEN-1:0]   diff;
  logic [XLEN-1:0]   quo_fix, rem_fix;

`ifdef ITER_DIVIDER_FLUSH_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  // Operand conditioning; magnitudes stay unsigned so -2^(XLEN-1) maps to 2^(XLEN-1).
  assign x_neg  = ~op[0] & X[XLEN-1];
  assign y_neg  = ~op[0] & Y[XLEN-1];
  assign x_abs  = x_neg ? (~X + 1'b1) : X;
  assign y_abs  = y_neg ? (~Y + 1'b1) : Y;
  assign y_zero = (Y == '0);
  assign ovf    = ~op[0] & (X == MIN_NEG) & (Y == '1);

  // One restoring step on an XLEN+1 bit partial remainder.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_q});
  assign diff   = rem_sh[XLEN-1:0] - dvs_q;

  assign quo_fix = (sgn_q & quo_neg_q) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = (sgn_q & rem_neg_q) ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    is_rem_d  = is_rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    out_d     = out_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !abort) begin
          sgn_d     = ~op[0];
          is_rem_d  = op[1];
          quo_neg_d = x_neg ^ y_neg;
          rem_neg_d = x_neg;
          if (y_zero) begin
            out_d   = op[1] ? X : '1;
            state_d = S_DONE;
          end else if (ovf) begin
            out_d   = op[1] ? '0 : X;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = x_abs;
            dvs_d   = y_abs;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_IT) begin
          state_d = S_FIX;
        end else begin
          rem_d = ge ? diff : rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ge};
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_FIX: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          out_d   = is_rem_q ? rem_fix : quo_fix;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (abort || out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      is_rem_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      is_rem_q  <= is_rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      out_q     <= out_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign OUTPUT    = out_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider (XLEN=64): latency, results, special cases, backpressure, async reset.
module tb_iter_divider;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] X;
  logic [XLEN-1:0] Y;
  logic [1:0]      op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] OUTPUT;
  logic            busy;
`ifdef ITER_DIVIDER_FLUSH_EN
  logic            flush;
`endif

  int checks   = 0;
  int failures = 0;

  iter_divider #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ITER_DIVIDER_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUTPUT    (OUTPUT),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Issue one op, measure edges from accept to out_valid, check result, then drain.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] x,
                        input logic [63:0] y, input int exp_lat, input logic [63:0] exp_val);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    X  = x;
    Y  = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    X = ~x;
    Y = ~y;
    op = ~o;
    if (exp_lat > 0) check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_out"}, OUTPUT, exp_val);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = '0;
    Y         = '0;
    op        = 2'd0;
`ifdef ITER_DIVIDER_FLUSH_EN
    flush     = 1'b0;
`endif
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_output", OUTPUT, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu_100_7", 2'd1, 64'd100, 64'd7, 66, 64'd14);
    run_op("remu_100_7", 2'd3, 64'd100, 64'd7, 66, 64'd2);
    run_op("div_m100_7", 2'd0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 66, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("rem_m100_7", 2'd2, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 66, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("rem_100_m7", 2'd2, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 66, 64'd2);
    run_op("div_100_m7", 2'd0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 66, 64'hFFFF_FFFF_FFFF_FFF2);
    run_op("div_min_2", 2'd0, 64'h8000_0000_0000_0000, 64'd2, 66, 64'hC000_0000_0000_0000);
    run_op("divu_min_ones", 2'd1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 66, 64'd0);
    run_op("remu_min_ones", 2'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 66,
           64'h8000_0000_0000_0000);
    run_op("divu_ones_1", 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op("div_by0", 2'd0, 64'd5, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("divu_by0", 2'd1, 64'd5, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("rem_by0", 2'd2, 64'd5, 64'd0, 0, 64'd5);
    run_op("remu_by0", 2'd3, 64'd5, 64'd0, 0, 64'd5);
    run_op("div_ovf", 2'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0,
           64'h8000_0000_0000_0000);
    run_op("rem_ovf", 2'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0);

    // Backpressure: hold the result while in_valid toggles with a would-be 1-edge op.
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'd1;
    X  = 64'd100;
    Y  = 64'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_lat", 64'(n), 64'd66);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      op = 2'd0;
      X  = 64'd5;
      Y  = 64'd0;
      @(posedge clk);
      #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_output", OUTPUT, 64'd14);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_idle", 64'(in_ready), 64'd1);

    // Asynchronous reset at iteration 30 of a long divide.
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'd1;
    X  = 64'd1000;
    Y  = 64'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_output", OUTPUT, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("divu_9_3", 2'd1, 64'd9, 64'd3, 66, 64'd3);

`ifdef ITER_DIVIDER_FLUSH_EN
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'd1;
    X  = 64'd100;
    Y  = 64'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_idle", 64'(in_ready), 64'd1);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    check("flush_no_valid", 64'(n), 64'd0);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    op = 2'd1;
    X  = 64'd5;
    Y  = 64'd0;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_blocks_accept", 64'(out_valid), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
